// File: rtl/uart_cmd_master_pkg.sv
// uart_cmd_pkg: shared definitions for the UART command master.
//   state_t       - command sequencing states
//   OP_*          - opcode constants understood by the remote responder
//   op_has_reply  - tells a caller whether an opcode produces a response byte
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEND_OP,
        WAIT_OP,
        SEND_ARG,
        WAIT_ARG,
        WAIT_RSP
    } state_t;

    // The responder reserves 0x00 to mean "no pending opcode".
    localparam logic [7:0] OP_ILLEGAL  = 8'h00;
    localparam logic [7:0] OP_CLK_SET  = 8'h10;
    localparam logic [7:0] OP_CLK_CLR  = 8'h11;
    localparam logic [7:0] OP_RST_SET  = 8'h12;
    localparam logic [7:0] OP_RST_CLR  = 8'h13;
    localparam logic [7:0] OP_PIN_RD   = 8'h20;
    localparam logic [7:0] OP_PIN_WR   = 8'h30;
    localparam logic [7:0] OP_REG_WR   = 8'h40;
    localparam logic [7:0] OP_REG_RD   = 8'h50;
    localparam logic [7:0] OP_MEM_WR   = 8'hA0;
    localparam logic [7:0] OP_MEM_RD   = 8'hA1;
    localparam logic [7:0] OP_MEM_WR4  = 8'hB0;

    // Pin reads (0x20-0x27) and register reads (0x50-0x57) answer with one byte.
    function automatic logic op_has_reply(input logic [7:0] op);
        return (op[7:3] == 5'b00100) || (op[7:3] == 5'b01010);
    endfunction

endpackage

// File: rtl/uart_cmd_master_if.sv
// uart_cmd_master_if: command request / completion bundle between an on-chip
// controller and uart_cmd_master.
//   master modport - the controller (issues commands, sees status pulses)
//   slave modport  - uart_cmd_master (accepts commands, reports status)
interface uart_cmd_master_if;
    import uart_cmd_pkg::*;

    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_op;
    logic [7:0] cmd_arg;
    logic       cmd_reply;
    logic       cmd_done;
    logic       cmd_err;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_timeout;
    logic       stray_rx;

    modport master (
        output cmd_valid, cmd_op, cmd_arg, cmd_reply,
        input  cmd_ready, cmd_done, cmd_err, rsp_valid, rsp_data,
               rsp_timeout, stray_rx
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_arg, cmd_reply,
        output cmd_ready, cmd_done, cmd_err, rsp_valid, rsp_data,
               rsp_timeout, stray_rx
    );

endinterface

// File: rtl/uart_cmd_master_byte_sender.sv
// uart_byte_sender: single-byte transmit handshake with the UART core.
//   clk, rst     - system clock, synchronous active-high reset
//   send         - caller is in a SEND phase; strobe as soon as the UART is free
//   wait_phase   - caller is in a WAIT phase; report when the byte has gone
//   byte_in      - byte to transmit (held stable by the caller)
//   tx_busy      - UART core transmitting
//   tx_en        - one-cycle send strobe
//   tx_data      - byte to the UART, held from the strobe until the next one
//   sent         - strobe issued this cycle
//   done         - byte finished (WAIT phase, past the first cycle, UART idle)
module uart_byte_sender
    import uart_cmd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       send,
    input  logic       wait_phase,
    input  logic [7:0] byte_in,
    input  logic       tx_busy,
    output logic       tx_en,
    output logic [7:0] tx_data,
    output logic       sent,
    output logic       done
);

    logic       first_q;
    logic [7:0] hold_q;

    assign tx_en = send & ~tx_busy;
    assign sent  = tx_en;

    // The UART core raises busy one cycle after the strobe, so the first
    // WAIT cycle must not trust a low busy.
    assign done = wait_phase & ~first_q & ~tx_busy;

    assign tx_data = tx_en ? byte_in : hold_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            first_q <= 1'b0;
            hold_q  <= 8'h00;
        end else begin
            first_q <= tx_en;
            if (tx_en) begin
                hold_q <= byte_in;
            end
        end
    end

endmodule

// File: rtl/uart_cmd_master.sv
// uart_cmd_master: sends a two-byte command (opcode, argument) through a
// byte-level UART core and optionally waits for one response byte.
//   sys_clk, sys_rst - clock, synchronous active-high reset
//   cmd              - command handshake and status pulses (slave modport)
//   uart_tx_en/data  - send strobe and byte to the UART core
//   uart_tx_busy     - UART core transmitting
//   uart_rx_done     - UART receive flag; a rising edge marks a new byte
//   uart_rx_data     - received byte
module uart_cmd_master
    import uart_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int TO_W           = 24
)(
    input  logic              sys_clk,
    input  logic              sys_rst,
    uart_cmd_master_if.slave  cmd,
    output logic              uart_tx_en,
    output logic [7:0]        uart_tx_data,
    input  logic              uart_tx_busy,
    input  logic              uart_rx_done,
    input  logic [7:0]        uart_rx_data
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    state_t          state, state_n;
    logic [7:0]      op_q, arg_q;
    logic            reply_q;
    logic [TO_W-1:0] to_cnt;
    logic            rx_done_q, rx_new;
    logic            accept, capture;
    logic            done_n, err_n, valid_n, timeout_n, stray_n;
    logic            send, wait_phase, sent, wait_done;
    logic [7:0]      tx_byte;

    assign rx_new        = uart_rx_done & ~rx_done_q;
    assign cmd.cmd_ready = (state == IDLE);

    assign send       = (state == SEND_OP) || (state == SEND_ARG);
    assign wait_phase = (state == WAIT_OP) || (state == WAIT_ARG);
    assign tx_byte    = ((state == SEND_OP) || (state == WAIT_OP)) ? op_q : arg_q;

    uart_byte_sender u_sender (
        .clk        (sys_clk),
        .rst        (sys_rst),
        .send       (send),
        .wait_phase (wait_phase),
        .byte_in    (tx_byte),
        .tx_busy    (uart_tx_busy),
        .tx_en      (uart_tx_en),
        .tx_data    (uart_tx_data),
        .sent       (sent),
        .done       (wait_done)
    );

    always_comb begin
        state_n   = state;
        accept    = 1'b0;
        capture   = 1'b0;
        done_n    = 1'b0;
        err_n     = 1'b0;
        valid_n   = 1'b0;
        timeout_n = 1'b0;
        stray_n   = rx_new & (state != WAIT_RSP);
        case (state)
            IDLE: begin
                if (cmd.cmd_valid) begin
                    accept = 1'b1;
                    if (cmd.cmd_op == OP_ILLEGAL) begin
                        done_n = 1'b1;
                        err_n  = 1'b1;
                    end else begin
                        state_n = SEND_OP;
                    end
                end
            end
            SEND_OP:  if (sent)      state_n = WAIT_OP;
            WAIT_OP:  if (wait_done) state_n = SEND_ARG;
            SEND_ARG: if (sent)      state_n = WAIT_ARG;
            WAIT_ARG: begin
                if (wait_done) begin
                    if (reply_q) begin
                        state_n = WAIT_RSP;
                    end else begin
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end
                end
            end
            WAIT_RSP: begin
                // A byte arriving in the timeout cycle still counts as a reply.
                if (rx_new) begin
                    capture = 1'b1;
                    valid_n = 1'b1;
                    done_n  = 1'b1;
                    state_n = IDLE;
                end else if (to_cnt == TO_LAST) begin
                    timeout_n = 1'b1;
                    err_n     = 1'b1;
                    done_n    = 1'b1;
                    state_n   = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state           <= IDLE;
            op_q            <= 8'h00;
            arg_q           <= 8'h00;
            reply_q         <= 1'b0;
            to_cnt          <= '0;
            rx_done_q       <= uart_rx_done;
            cmd.cmd_done    <= 1'b0;
            cmd.cmd_err     <= 1'b0;
            cmd.rsp_valid   <= 1'b0;
            cmd.rsp_data    <= 8'h00;
            cmd.rsp_timeout <= 1'b0;
            cmd.stray_rx    <= 1'b0;
        end else begin
            state           <= state_n;
            rx_done_q       <= uart_rx_done;
            cmd.cmd_done    <= done_n;
            cmd.cmd_err     <= err_n;
            cmd.rsp_valid   <= valid_n;
            cmd.rsp_timeout <= timeout_n;
            cmd.stray_rx    <= stray_n;
            if (accept) begin
                op_q    <= cmd.cmd_op;
                arg_q   <= cmd.cmd_arg;
                reply_q <= cmd.cmd_reply;
            end
            if (capture) begin
                cmd.rsp_data <= uart_rx_data;
            end
            // Counter runs only while waiting for a reply and saturates.
            if (state == WAIT_RSP) begin
                if (to_cnt != '1) begin
                    to_cnt <= to_cnt + 1'b1;
                end
            end else begin
                to_cnt <= '0;
            end
        end
    end

endmodule

// File: doc/uart_cmd_master.md
Name: uart_cmd_master

Overview:
- Host-side initiator for the two-byte UART command protocol: sends opcode byte then argument byte, and optionally waits for a single response byte, with a timeout.
- Sits between an on-chip controller (test sequencer, soft CPU bridge) and the byte-level UART core. Drives the command-decoding responder on a remote or second FPGA.
- Handles one command at a time. No queueing.

Parameters:
- TIMEOUT_CYCLES, 1000000, sys_clk cycles to wait for a response byte before giving up (must be ≥2).
- TO_W, 24, width of the timeout counter; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- sys_clk  in  1  single clock; all logic on its rising edge.
- sys_rst  in  1  reset; synchronous, active-high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE; transfer occurs when cmd_valid & cmd_ready.
- cmd_op  in  8  opcode byte; 0x00 is illegal.
- cmd_arg  in  8  argument byte; any value is legal.
- cmd_reply  in  1  1 = expect one response byte.
- cmd_done  out  1  one-cycle pulse when a command finishes: sent, replied, or timed out.
- cmd_err  out  1  one-cycle pulse: the opcode was 0x00, or a timeout occurred.
- rsp_valid  out  1  one-cycle pulse when a response byte is captured.
- rsp_data  out  8  last captured response byte; holds its value between commands.
- rsp_timeout  out  1  one-cycle pulse on timeout.
- stray_rx  out  1  one-cycle pulse when a byte arrives outside WAIT_RSP.
- uart_tx_en  out  1  one-cycle send strobe to the UART core.
- uart_tx_data  out  8  byte to send; stable from the strobe until the byte completes.
- uart_tx_busy  in  1  UART core transmitting.
- uart_rx_done  in  1  UART core receive flag; its rising edge marks a new byte.
- uart_rx_data  in  8  received byte; valid on the rising edge of uart_rx_done.

Behaviour:
- Reset values: all outputs 0 except cmd_ready = 1. rsp_data = 0. State = IDLE. Timeout counter = 0. rx_done_q is loaded with uart_rx_done, so no false edge is seen on reset release.
- RX edge detect: rx_new = uart_rx_done & ~rx_done_q, where rx_done_q is uart_rx_done registered one cycle.
- States: IDLE, SEND_OP, WAIT_OP, SEND_ARG, WAIT_ARG, WAIT_RSP.
- IDLE:
  - On accept, latch op, arg and reply.
  - If op == 0x00: pulse cmd_err and cmd_done next cycle, send nothing, stay in IDLE. Reason: the responder treats 0x00 as "no pending opcode".
  - Otherwise go to SEND_OP.
- SEND_OP: when uart_tx_busy == 0, assert uart_tx_en with uart_tx_data = op, then go to WAIT_OP. With an idle UART, the first strobe appears 1 cycle after accept.
- WAIT_OP: ignore uart_tx_busy on the first cycle (UART core latency). Afterwards, when uart_tx_busy == 0, go to SEND_ARG.
- SEND_ARG and WAIT_ARG: same rules as SEND_OP and WAIT_OP, with the byte = arg. On completion:
  - if reply == 1: clear the counter and go to WAIT_RSP;
  - otherwise: pulse cmd_done and go to IDLE.
- WAIT_RSP: the counter increments every cycle.
  - On rx_new: rsp_data <= uart_rx_data, pulse rsp_valid and cmd_done, go to IDLE.
  - Else if counter == TIMEOUT_CYCLES-1: pulse rsp_timeout, cmd_err and cmd_done, go to IDLE. rsp_data is unchanged.
  - If rx_new and the timeout fall in the same cycle, the byte wins and no timeout is flagged.
- Any byte whose rx_new occurs outside WAIT_RSP is discarded and pulses stray_rx. rsp_data is unchanged.
- cmd_ready is deasserted from the cycle after accept until the cycle after return to IDLE. Back-to-back commands are therefore separated by at least 1 idle cycle.
- uart_tx_en never asserts while uart_tx_busy == 1, and never for 2 consecutive cycles.
- Reset mid-command: next edge returns to IDLE and drops uart_tx_en. No completion pulse. Any partially sent opcode leaves the responder holding a pending opcode; re-synchronising the responder (resetting it) is the integrator's responsibility.
- The counter saturates and never wraps.

Decomposition:
- Shared package uart_cmd_pkg holds:
  - the state enum;
  - opcode constants: OP_CLK_SET 0x10, OP_CLK_CLR 0x11, OP_RST_SET 0x12, OP_RST_CLR 0x13, OP_PIN_RD base 0x20, OP_PIN_WR base 0x30, OP_REG_WR base 0x40, OP_REG_RD base 0x50, OP_MEM_WR 0xA0, OP_MEM_RD 0xA1, OP_MEM_WR4 0xB0;
  - function op_has_reply(op), returning 1 for 0x20–0x27 and 0x50–0x57, for callers that set cmd_reply.
- One sub-module is natural: uart_byte_sender, covering the SEND/WAIT tx handshake, instantiated once and reused for both bytes.

Test Plan:
- Write, no reply: op 0x31, arg 0x5A, reply 0, idle UART model with 10-cycle busy → tx bytes 0x31 then 0x5A. First strobe 1 cycle after accept. cmd_done once; rsp_valid never.
- Read with reply: op 0x52, arg 0x00, reply 1; model answers 0xC3 50 cycles after arg completes → rsp_valid and cmd_done pulse together, rsp_data = 0xC3, cmd_err = 0.
- Timeout: TIMEOUT_CYCLES = 100, op 0x21, reply 1, no answer → rsp_timeout, cmd_err and cmd_done exactly 100 cycles after entering WAIT_RSP. rsp_data keeps its previous value 0xC3.
- Boundaries:
  - op 0x00 → no uart_tx_en, cmd_err and cmd_done 1 cycle after accept;
  - byte arrives in the timeout cycle → rsp_valid, no rsp_timeout;
  - byte while IDLE → stray_rx only.
- Busy/back-pressure: uart_tx_busy held high 30 cycles at accept → first strobe the cycle after busy drops; never a strobe while busy.
- Reset mid-command: assert sys_rst during WAIT_ARG → next cycle state is IDLE, cmd_ready = 1, no uart_tx_en, no cmd_done. The next command completes normally.
